data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_if.sv | 28 ++
 rtl/data_memory_responder.sv | 115 +++++++++++
 tb/tb_data_memory_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_if
// Brief    : Request/response bundle between memory control and the data RAM
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_responder_if;
    logic        memory_enable;
    logic        RW;
    logic [31:0] address_in;
    logic [31:0] RAM_in;
    logic [31:0] RAM_out;
    logic        mem_ready;
    logic        busy;
    logic        addr_fault;

    modport master (
        output memory_enable, RW, address_in, RAM_in,
        input  RAM_out, mem_ready, busy, addr_fault
    );

    modport slave (
        input  memory_enable, RW, address_in, RAM_in,
        output RAM_out, mem_ready, busy, addr_fault
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Brief    : Word-addressed data RAM with wait states, bounds check and
//            post-reset clearing sweep
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic              clk,
    input  wire logic              Reset,
    data_memory_responder_if.slave bus
);

    localparam logic [1:0]           c_st_clear  = 2'd0;
    localparam logic [1:0]           c_st_idle   = 2'd1;
    localparam logic [1:0]           c_st_wait   = 2'd2;
    localparam logic [1:0]           c_st_done   = 2'd3;
    localparam logic [3:0]           c_wait_load = 4'(WAIT_CYCLES);
    localparam logic [ADDR_BITS-1:0] c_last_idx  = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] c_idx_one   = ADDR_BITS'(1);

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_sweep;
    logic [3:0]           r_wait;
    logic                 r_rw;
    logic [ADDR_BITS-1:0] r_idx;
    logic [31:0]          r_wdata;
    logic                 r_fault;
    logic [31:0]          r_ram_out;
    logic [31:0]          r_mem [DEPTH];

    logic [ADDR_BITS-1:0] w_req_idx;
    logic                 w_req_fault;

    // Upper address bits only feed the range check; they never alias into the index.
    assign w_req_idx   = bus.address_in[ADDR_BITS-1:0];
    assign w_req_fault = (bus.address_in >= 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= c_st_clear;
            r_sweep   <= '0;
            r_wait    <= '0;
            r_rw      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_fault   <= 1'b0;
            r_ram_out <= '0;
        end else begin
            case (r_state)
                c_st_clear: begin
                    r_sweep <= r_sweep + c_idx_one;
                    if (r_sweep == c_last_idx) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_idle: begin
                    if (bus.memory_enable) begin
                        r_rw    <= bus.RW;
                        r_idx   <= w_req_idx;
                        r_wdata <= bus.RAM_in;
                        r_fault <= w_req_fault;
                        r_wait  <= c_wait_load;
                        if (c_wait_load != 4'd0) begin
                            r_state <= c_st_wait;
                        end else begin
                            r_state <= c_st_done;
                            if (bus.RW) begin
                                r_ram_out <= w_req_fault ? '0 : r_mem[w_req_idx];
                            end
                        end
                    end
                end
                c_st_wait: begin
                    r_wait <= r_wait - 4'd1;
                    if (r_wait == 4'd1) begin
                        r_state <= c_st_done;
                        if (r_rw) begin
                            r_ram_out <= r_fault ? '0 : r_mem[r_idx];
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_clear;
                end
            endcase
        end
    end

    // Writes commit on the edge leaving DONE, so an aborting reset drops them.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (r_state == c_st_clear) begin
                r_mem[r_sweep] <= '0;
            end else if ((r_state == c_st_done) && !r_rw && !r_fault) begin
                r_mem[r_idx] <= r_wdata;
            end
        end
    end

    assign bus.RAM_out    = r_ram_out;
    assign bus.mem_ready  = (r_state == c_st_done);
    assign bus.addr_fault = (r_state == c_st_done) && r_fault;
    assign bus.busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Brief    : Randomized self-checking bench against an array-based memory model
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder_if bus1 ();
    data_memory_responder_if bus0 ();

    data_memory_responder #(.DEPTH(256), .ADDR_BITS(8), .WAIT_CYCLES(1)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    data_memory_responder #(.DEPTH(256), .ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus0.slave)
    );

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] model_mem [2][256];
    logic [31:0] model_out [2];
    int          last_ready [2];
    bit          prev_hold [2];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // sel 0 -> WAIT_CYCLES=1 instance, sel 1 -> WAIT_CYCLES=0 instance
    task automatic drive(input int sel, input logic en, input logic rw,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            bus1.memory_enable = en; bus1.RW = rw; bus1.address_in = addr; bus1.RAM_in = data;
        end else begin
            bus0.memory_enable = en; bus0.RW = rw; bus0.address_in = addr; bus0.RAM_in = data;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus1.busy : bus0.busy;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus1.mem_ready : bus0.mem_ready;
    endfunction
    function automatic logic get_fault(input int sel);
        return (sel == 0) ? bus1.addr_fault : bus0.addr_fault;
    endfunction
    function automatic logic [31:0] get_out(input int sel);
        return (sel == 0) ? bus1.RAM_out : bus0.RAM_out;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) model_mem[s][i] = '0;
            model_out[s] = '0;
            prev_hold[s] = 1'b0;
        end
    endtask

    // Reset edge has already happened; count cycles spent sweeping.
    task automatic check_clear(input string tag);
        int n;
        n = 0;
        while (bus1.busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check_value(tag, 32'(n), 32'd256);
        check_value("dut0_idle_after_clear", {31'd0, bus0.busy}, 32'd0);
    endtask

    task automatic do_access(input int sel, input logic rw, input logic [31:0] addr,
                             input logic [31:0] data, input bit hold);
        int          n;
        int          waitc;
        logic        exp_fault;
        waitc = (sel == 0) ? 1 : 0;
        drive(sel, 1'b1, rw, addr, data);
        n = 0;
        while (get_busy(sel) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (get_busy(sel)) check_value("idle_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        // Scramble the bus once accepted: the responder must use latched values.
        drive(sel, hold, $urandom_range(0, 1), $urandom, $urandom);
        exp_fault = (addr >= 32'd256);
        if (!exp_fault) begin
            if (rw) model_out[sel] = model_mem[sel][addr % 256];
            else    model_mem[sel][addr % 256] = data;
        end else if (rw) begin
            model_out[sel] = '0;
        end
        check_value("busy_after_accept", {31'd0, get_busy(sel)}, 32'd1);
        n = 1;
        while (!get_ready(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_value("latency", 32'(n), 32'(waitc + 1));
        check_value("addr_fault", {31'd0, get_fault(sel)}, {31'd0, exp_fault});
        check_value("ram_out", get_out(sel), model_out[sel]);
        if (prev_hold[sel]) check_value("period", 32'(cyc - last_ready[sel]), 32'(waitc + 2));
        last_ready[sel] = cyc;
        prev_hold[sel]  = hold;
        if (!hold) begin
            @(posedge clk); #1;
            check_value("ready_pulse_width", {31'd0, get_ready(sel)}, 32'd0);
            check_value("fault_after_done", {31'd0, get_fault(sel)}, 32'd0);
        end
    endtask

    initial begin
        int          pulses;
        int          sel;
        int          burst;
        int          r;
        logic [31:0] addr;

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        model_reset();
        @(posedge clk); #1;
        Reset = 1'b0;
        check_value("reset_ram_out", bus1.RAM_out, 32'd0);
        check_value("reset_ready", {31'd0, bus1.mem_ready}, 32'd0);
        check_value("reset_fault", {31'd0, bus1.addr_fault}, 32'd0);
        check_value("reset_busy", {31'd0, bus1.busy}, 32'd1);
        check_clear("clear_cycles");

        do_access(0, 1'b1, 32'h10, '0, 1'b0);
        do_access(0, 1'b0, 32'h5, 32'hDEADBEEF, 1'b0);
        do_access(0, 1'b1, 32'h5, '0, 1'b0);

        for (int i = 0; i < 4; i++) do_access(0, 1'b0, 32'(i), $urandom, 1'b1);
        for (int i = 0; i < 4; i++) do_access(0, 1'b1, 32'(i), '0, (i != 3));

        do_access(0, 1'b1, 32'h100, '0, 1'b0);
        do_access(0, 1'b0, 32'h100, 32'h12345678, 1'b0);
        do_access(0, 1'b1, 32'h0, '0, 1'b0);

        // Abort a write with reset while it is waiting.
        do_access(0, 1'b1, 32'h5, '0, 1'b0);
        drive(0, 1'b1, 1'b0, 32'h7, 32'hA5A5A5A5);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        check_value("abort_in_wait", {31'd0, bus1.busy}, 32'd1);
        Reset = 1'b1;
        pulses = 0;
        @(posedge clk); #1;
        if (bus1.mem_ready) pulses++;
        Reset = 1'b0;
        model_reset();
        check_value("reset_ram_out_after_read", bus1.RAM_out, 32'd0);
        check_clear("clear_cycles_abort");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus1.mem_ready) pulses++;
        end
        check_value("aborted_ready_pulses", 32'(pulses), 32'd0);
        do_access(0, 1'b1, 32'h7, '0, 1'b0);

        do_access(1, 1'b0, 32'h3, 32'h11, 1'b0);
        do_access(1, 1'b1, 32'h3, '0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            sel   = $urandom_range(0, 1);
            burst = $urandom_range(1, 4);
            for (int b = 0; b < burst; b++) begin
                r = $urandom_range(0, 9);
                if (r < 7)       addr = 32'($urandom_range(0, 15));
                else if (r == 7) addr = 32'($urandom_range(0, 255));
                else if (r == 8) addr = 32'h100 + 32'($urandom_range(0, 15));
                else             addr = $urandom;
                do_access(sel, 1'($urandom_range(0, 1)), addr, $urandom, (b != burst - 1));
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
